// File: rtl/db_left_pp_ram.sv
// Ping-pong deblocking left-pixel store: two flop banks with per-entry valid bits, byte-masked writes, registered reads.
// Optional `DB_LEFT_PP_RAM_FWD_EN selects write-first forwarding on same-entry read/write; default is read-first.
module db_left_pp_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cena_i,
    input  logic                    wena_i,
    input  logic [ADDR_WIDTH-1:0]   addra_i,
    input  logic [DATA_WIDTH/8-1:0] maska_i,
    input  logic [DATA_WIDTH-1:0]   dataa_i,
    input  logic                    cenb_i,
    input  logic                    selb_i,
    input  logic [ADDR_WIDTH-1:0]   addrb_i,
    output logic [DATA_WIDTH-1:0]   datab_o,
    output logic                    validb_o,
    output logic                    hitb_o,
    input  logic                    swap_i,
    output logic                    bank_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    // Entry {b, a} lives at index b*DEPTH + a, so each bank is a contiguous slice.
    logic [DATA_WIDTH-1:0] mem [2*DEPTH];
    logic [2*DEPTH-1:0]    valid;
    logic [2*DEPTH-1:0]    valid_nxt;
    logic                  bank;

    logic                  wr_stb;
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   wr_idx;
    logic                  wr_old_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH:0]   rd_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_hit;

    assign wr_stb       = !cena_i && !wena_i;
    assign wr_en        = wr_stb && (|maska_i);
    assign wr_idx       = {bank, addra_i};
    assign wr_old_valid = valid[wr_idx];
    assign rd_idx       = {selb_i ? bank : ~bank, addrb_i};
    assign bank_o       = bank;

    // Unwritten bytes of a stale (invalid) entry are zeroed rather than kept.
    always_comb begin
        for (int i = 0; i < BYTES; i++) begin
            wr_data[i*8 +: 8] = maska_i[i] ? dataa_i[i*8 +: 8]
                                           : (wr_old_valid ? mem[wr_idx][i*8 +: 8] : 8'h00);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        valid_nxt = valid;
        if (swap_i) begin
            if (bank) valid_nxt[0 +: DEPTH]     = '0;
            else      valid_nxt[DEPTH +: DEPTH] = '0;
        end
        if (wr_en) valid_nxt[wr_idx] = 1'b1;
    end

    always_comb begin
        rd_data = mem[rd_idx];
        rd_hit  = valid[rd_idx];
`ifdef DB_LEFT_PP_RAM_FWD_EN
        if (selb_i && wr_stb && (addra_i == addrb_i)) begin
            rd_data = wr_data;
            rd_hit  = wr_old_valid | (|maska_i);
        end
`endif
    end

    // NOTE: storage array has no reset; the valid bits alone define what is readable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank     <= 1'b0;
            valid    <= '0;
            datab_o  <= '0;
            validb_o <= 1'b0;
            hitb_o   <= 1'b0;
        end else begin
            if (swap_i) bank <= ~bank;
            valid    <= valid_nxt;
            validb_o <= !cenb_i;
            if (!cenb_i) begin
                datab_o <= rd_hit ? rd_data : '0;
                hitb_o  <= rd_hit;
            end
        end
    end
endmodule

// File: tb/tb_db_left_pp_ram.sv
// Directed self-checking bench for db_left_pp_ram (128-bit entries, 16 per bank).
module tb_db_left_pp_ram;
    logic         clk = 1'b0;
    logic         rst;
    logic         cena_i, wena_i, cenb_i, selb_i, swap_i;
    logic [3:0]   addra_i, addrb_i;
    logic [15:0]  maska_i;
    logic [127:0] dataa_i;
    logic [127:0] datab_o;
    logic         validb_o, hitb_o, bank_o;

    int n_checks = 0;
    int n_errors = 0;

    db_left_pp_ram #(.DATA_WIDTH(128), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .cena_i(cena_i), .wena_i(wena_i), .addra_i(addra_i), .maska_i(maska_i), .dataa_i(dataa_i),
        .cenb_i(cenb_i), .selb_i(selb_i), .addrb_i(addrb_i),
        .datab_o(datab_o), .validb_o(validb_o), .hitb_o(hitb_o),
        .swap_i(swap_i), .bank_o(bank_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cena_i = 1'b1; wena_i = 1'b1; cenb_i = 1'b1; swap_i = 1'b0;
        maska_i = '0; dataa_i = '0; addra_i = '0; addrb_i = '0; selb_i = 1'b0;
    endtask

    task automatic set_wr(input logic [3:0] a, input logic [15:0] m, input logic [127:0] d);
        cena_i = 1'b0; wena_i = 1'b0; addra_i = a; maska_i = m; dataa_i = d;
    endtask

    task automatic set_rd(input logic sel, input logic [3:0] a);
        cenb_i = 1'b0; selb_i = sel; addrb_i = a;
    endtask

    task automatic expect_rd(input string tag, input logic [127:0] d, input logic h);
        check({tag, "_valid"}, {127'd0, validb_o}, 128'd1);
        check({tag, "_data"}, datab_o, d);
        check({tag, "_hit"}, {127'd0, hitb_o}, {127'd0, h});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state and reads of empty banks
        check("rst_bank", {127'd0, bank_o}, 128'd0);
        check("rst_valid", {127'd0, validb_o}, 128'd0);
        check("rst_data", datab_o, 128'd0);
        check("rst_hit", {127'd0, hitb_o}, 128'd0);
        set_rd(1'b0, 4'd3); tick();
        expect_rd("t1_rd_bank1", 128'd0, 1'b0);
        set_rd(1'b1, 4'd3); tick();
        expect_rd("t1_rd_bank0", 128'd0, 1'b0);
        idle(); tick();
        check("t1_no_req_valid", {127'd0, validb_o}, 128'd0);

        // 2: write bank 0, swap, read it back as the read bank
        set_wr(4'd5, 16'hFFFF, {16{8'h0F}}); tick();
        idle(); swap_i = 1'b1; tick();
        idle();
        check("t2_bank", {127'd0, bank_o}, 128'd1);
        set_rd(1'b0, 4'd5); tick();
        expect_rd("t2_rd", {16{8'h0F}}, 1'b1);
        idle(); tick();
        check("t2_hold_data", datab_o, {16{8'h0F}});

        // 3: partial byte writes into an invalid entry of bank 1
        set_wr(4'd2, 16'h0001, {{15{8'hFF}}, 8'hAB}); tick();
        idle(); set_rd(1'b1, 4'd2); tick();
        expect_rd("t3_byte0", {120'd0, 8'hAB}, 1'b1);
        idle(); set_wr(4'd2, 16'h8000, {8'hCD, {15{8'h77}}}); tick();
        idle(); set_rd(1'b1, 4'd2); tick();
        expect_rd("t3_byte15", {8'hCD, 112'd0, 8'hAB}, 1'b1);
        idle(); set_wr(4'd9, 16'h0000, {16{8'h99}}); tick();
        idle(); set_rd(1'b1, 4'd9); tick();
        expect_rd("t3_mask0_noop", 128'd0, 1'b0);

        // 4: same-edge collisions in bank 1 (write bank)
        idle(); set_wr(4'd7, 16'hFFFF, {16{8'h22}}); tick();
        idle(); set_wr(4'd7, 16'hFFFF, {16{8'h11}}); set_rd(1'b1, 4'd7); tick();
`ifdef DB_LEFT_PP_RAM_FWD_EN
        expect_rd("t4_collide", {16{8'h11}}, 1'b1);
`else
        expect_rd("t4_collide", {16{8'h22}}, 1'b1);
`endif
        idle(); set_rd(1'b1, 4'd7); tick();
        expect_rd("t4_after", {16{8'h11}}, 1'b1);
        idle(); set_wr(4'd5, 16'hFFFF, {16{8'h33}}); set_rd(1'b0, 4'd5); tick();
        expect_rd("t4_readbank", {16{8'h0F}}, 1'b1);
        idle(); set_wr(4'd12, 16'h00FF, {16{8'h55}}); set_rd(1'b1, 4'd12); tick();
`ifdef DB_LEFT_PP_RAM_FWD_EN
        expect_rd("t4_collide_inv", {64'd0, {8{8'h55}}}, 1'b1);
`else
        expect_rd("t4_collide_inv", 128'd0, 1'b0);
`endif

        // 5: double swap clears both banks; write+swap keeps the written entry
        idle(); swap_i = 1'b1; tick();
        idle();
        check("t5_bank0", {127'd0, bank_o}, 128'd0);
        set_wr(4'd1, 16'hFFFF, {16{8'hAA}}); tick();
        idle(); swap_i = 1'b1; tick(); tick();
        idle();
        check("t5_bank_dbl", {127'd0, bank_o}, 128'd0);
        set_rd(1'b1, 4'd1); tick();
        expect_rd("t5_cleared0", 128'd0, 1'b0);
        idle(); set_rd(1'b0, 4'd5); tick();
        expect_rd("t5_cleared1", 128'd0, 1'b0);
        idle(); set_wr(4'd4, 16'hFFFF, {16{8'h44}}); swap_i = 1'b1; tick();
        idle();
        check("t5_bank_ws", {127'd0, bank_o}, 128'd1);
        set_rd(1'b0, 4'd4); tick();
        expect_rd("t5_wr_swap_kept", {16{8'h44}}, 1'b1);
        idle(); set_rd(1'b1, 4'd4); tick();
        expect_rd("t5_new_wbank", 128'd0, 1'b0);

        // 6: reset discards an outstanding read; back-to-back reads
        idle(); set_rd(1'b0, 4'd4); tick();
        rst = 1'b1; tick();
        check("t6_rst_valid", {127'd0, validb_o}, 128'd0);
        check("t6_rst_data", datab_o, 128'd0);
        check("t6_rst_bank", {127'd0, bank_o}, 128'd0);
        rst = 1'b0; idle();
        set_wr(4'd6, 16'hFFFF, {16{8'h66}}); tick();
        set_wr(4'd8, 16'hFFFF, {16{8'h88}}); tick();
        idle(); swap_i = 1'b1; tick();
        idle();
        set_rd(1'b0, 4'd6); tick();
        expect_rd("t6_b2b_0", {16{8'h66}}, 1'b1);
        set_rd(1'b0, 4'd8); tick();
        expect_rd("t6_b2b_1", {16{8'h88}}, 1'b1);
        set_rd(1'b0, 4'd4); tick();
        expect_rd("t6_b2b_2", 128'd0, 1'b0);
        set_rd(1'b0, 4'd6); tick();
        expect_rd("t6_b2b_3", {16{8'h66}}, 1'b1);
        idle(); tick();
        check("t6_end_valid", {127'd0, validb_o}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
